// File: rtl/wb_stage.sv
// Writeback stage: one stage register, GRF write port, decode bypass, retire count.
// Optional WB_LOADEXT_EN builds byte/half load extraction and extension.
module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic [4:0]  m_rd,
    input  logic        m_regwrite,
    input  logic [1:0]  m_wbsel,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_memdata,
    input  logic [2:0]  m_ldtype,
    input  logic [1:0]  m_addrlo,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] pc,
    output logic [4:0]  A3,
    output logic [31:0] writedata,
    output logic        regwrite,
    input  logic [4:0]  q_a1,
    input  logic [4:0]  q_a2,
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd_data,
    output logic [31:0] retired
);

    logic        valid_r;
    logic        done_r;
    logic [31:0] pc_r;
    logic [4:0]  rd_r;
    logic        regwrite_r;
    logic [1:0]  wbsel_r;
    logic [31:0] alu_r;
    logic [31:0] memdata_r;
    logic [2:0]  ldtype_r;
    logic [1:0]  addrlo_r;
    logic [31:0] retired_r;
    logic [31:0] load_data;
    logic        writes_reg;

    // Stage register: reset > flush > stall > capture
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r    <= 1'b0;
            done_r     <= 1'b0;
            pc_r       <= 32'h0;
            rd_r       <= 5'h0;
            regwrite_r <= 1'b0;
            wbsel_r    <= 2'b00;
            alu_r      <= 32'h0;
            memdata_r  <= 32'h0;
            ldtype_r   <= 3'b000;
            addrlo_r   <= 2'b00;
        end else if (flush) begin
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else if (stall) begin
            if (valid_r) begin
                done_r <= 1'b1;
            end
        end else begin
            valid_r    <= m_valid;
            done_r     <= 1'b0;
            pc_r       <= m_pc;
            rd_r       <= m_rd;
            regwrite_r <= m_regwrite;
            wbsel_r    <= m_wbsel;
            alu_r      <= m_alu;
            memdata_r  <= m_memdata;
            ldtype_r   <= m_ldtype;
            addrlo_r   <= m_addrlo;
        end
    end

    // Retire counter: one count per instruction, the cycle before it is marked done
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_r <= 32'h0;
        end else if (valid_r && !done_r) begin
            retired_r <= retired_r + 32'd1;
        end
    end

`ifdef WB_LOADEXT_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Little-endian lane select followed by sign/zero extension
    always_comb begin
        ld_byte   = memdata_r[{addrlo_r, 3'b000} +: 8];
        ld_half   = addrlo_r[1] ? memdata_r[31:16] : memdata_r[15:0];
        load_data = memdata_r;
        case (ldtype_r)
            3'b001:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b010:  load_data = {24'h0, ld_byte};
            3'b011:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {16'h0, ld_half};
            default: load_data = memdata_r;
        endcase
    end
`else
    logic unused_ldext;

    assign load_data    = memdata_r;
    assign unused_ldext = ^{ldtype_r, addrlo_r};
`endif

    // Writeback source mux
    always_comb begin
        writedata = 32'h0;
        case (wbsel_r)
            2'b00:   writedata = alu_r;
            2'b01:   writedata = load_data;
            2'b10:   writedata = pc_r + 32'd8;
            default: writedata = 32'h0;
        endcase
    end

    assign writes_reg = valid_r & regwrite_r & (rd_r != 5'd0);

    // A held instruction writes once; the bypass keeps serving it while held
    assign regwrite = writes_reg & ~done_r;
    assign fwd1_hit = writes_reg & (q_a1 == rd_r);
    assign fwd2_hit = writes_reg & (q_a2 == rd_r);
    assign fwd_data = writedata;
    assign A3       = rd_r;
    assign pc       = pc_r;
    assign retired  = retired_r;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage.
// Load expectations follow WB_LOADEXT_EN when it is defined.
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [4:0]  m_rd;
    logic        m_regwrite;
    logic [1:0]  m_wbsel;
    logic [31:0] m_alu;
    logic [31:0] m_memdata;
    logic [2:0]  m_ldtype;
    logic [1:0]  m_addrlo;
    logic        stall;
    logic        flush;
    logic [31:0] pc;
    logic [4:0]  A3;
    logic [31:0] writedata;
    logic        regwrite;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd_data;
    logic [31:0] retired;

    int checks;
    int errors;
    logic [31:0] exp_ret;

    wb_stage dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_pc(m_pc), .m_rd(m_rd),
        .m_regwrite(m_regwrite), .m_wbsel(m_wbsel), .m_alu(m_alu),
        .m_memdata(m_memdata), .m_ldtype(m_ldtype), .m_addrlo(m_addrlo),
        .stall(stall), .flush(flush),
        .pc(pc), .A3(A3), .writedata(writedata), .regwrite(regwrite),
        .q_a1(q_a1), .q_a2(q_a2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd_data(fwd_data), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] ipc, input logic [4:0] ird,
                             input logic irw, input logic [1:0] isel,
                             input logic [31:0] ialu, input logic [31:0] imem,
                             input logic [2:0] ild, input logic [1:0] ialo);
        m_valid    = 1'b1;
        m_pc       = ipc;
        m_rd       = ird;
        m_regwrite = irw;
        m_wbsel    = isel;
        m_alu      = ialu;
        m_memdata  = imem;
        m_ldtype   = ild;
        m_addrlo   = ialo;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        stall = 1'b1;
        flush = 1'b1;
        set_instr(32'h100, 5'd4, 1'b1, 2'b00, 32'h55, 32'h0, 3'b000, 2'b00);
        q_a1 = 5'd4;
        q_a2 = 5'd4;
        tick();
        tick();
        checks++;
        if (pc !== 32'h0) begin
            errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0);
        end
        checks++;
        if (A3 !== 5'd0) begin
            errors++; $display("FAIL reset_a3 got=%0d exp=0", A3);
        end
        checks++;
        if (writedata !== 32'h0) begin
            errors++; $display("FAIL reset_wd got=%h exp=0", writedata);
        end
        checks++;
        if ({regwrite, fwd1_hit, fwd2_hit} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl got=%b exp=000", {regwrite, fwd1_hit, fwd2_hit});
        end
        checks++;
        if (retired !== 32'h0) begin
            errors++; $display("FAIL reset_ret got=%0d exp=0", retired);
        end
        reset   = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        m_valid = 1'b0;
        tick();
        exp_ret = 32'd0;
    endtask

    task automatic test_alu;
        set_instr(32'h0000_3000, 5'd5, 1'b1, 2'b00, 32'h1234_5678,
                  32'h0, 3'b000, 2'b00);
        q_a1 = 5'd5;
        q_a2 = 5'd6;
        tick();
        m_valid = 1'b0;
        checks++;
        if ({regwrite, A3} !== {1'b1, 5'd5}) begin
            errors++; $display("FAIL alu_rw_a3 got=%b/%0d exp=1/5", regwrite, A3);
        end
        checks++;
        if (writedata !== 32'h1234_5678 || fwd_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL alu_wd got=%h/%h exp=12345678", writedata, fwd_data);
        end
        checks++;
        if (pc !== 32'h0000_3000) begin
            errors++; $display("FAIL alu_pc got=%h exp=00003000", pc);
        end
        checks++;
        if ({fwd1_hit, fwd2_hit} !== 2'b10) begin
            errors++; $display("FAIL alu_fwd got=%b exp=10", {fwd1_hit, fwd2_hit});
        end
        checks++;
        if (retired !== exp_ret) begin
            errors++; $display("FAIL alu_ret0 got=%0d exp=%0d", retired, exp_ret);
        end
        tick();
        exp_ret = exp_ret + 1;
        checks++;
        if (retired !== exp_ret || regwrite !== 1'b0) begin
            errors++;
            $display("FAIL alu_ret1 got=%0d/%b exp=%0d/0", retired, regwrite, exp_ret);
        end
    endtask

    task automatic test_load;
        logic [2:0]  lds [8];
        logic [1:0]  alos[8];
        logic [31:0] exps[8];
        lds = '{3'b001, 3'b100, 3'b001, 3'b010,
                3'b011, 3'b011, 3'b000, 3'b111};
        alos = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd1, 2'd3};
`ifdef WB_LOADEXT_EN
        exps = '{32'hFFFF_FFF0, 32'h0000_8070, 32'hFFFF_FF80, 32'h0000_0060,
                 32'h0000_60F0, 32'hFFFF_8070, 32'h8070_60F0, 32'h8070_60F0};
`else
        exps = '{32'h8070_60F0, 32'h8070_60F0, 32'h8070_60F0, 32'h8070_60F0,
                 32'h8070_60F0, 32'h8070_60F0, 32'h8070_60F0, 32'h8070_60F0};
`endif
        for (int i = 0; i < 8; i++) begin
            set_instr(32'h400, 5'd10, 1'b1, 2'b01, 32'h0,
                      32'h8070_60F0, lds[i], alos[i]);
            tick();
            checks++;
            if (writedata !== exps[i] || regwrite !== 1'b1) begin
                errors++;
                $display("FAIL load_%0d got=%h/%b exp=%h/1",
                         i, writedata, regwrite, exps[i]);
            end
        end
        m_valid = 1'b0;
        tick();
        exp_ret = exp_ret + 8;
        checks++;
        if (retired !== exp_ret) begin
            errors++; $display("FAIL load_ret got=%0d exp=%0d", retired, exp_ret);
        end
    endtask

    task automatic test_stall;
        set_instr(32'h500, 5'd7, 1'b1, 2'b00, 32'hA5, 32'h0, 3'b000, 2'b00);
        q_a1 = 5'd7;
        q_a2 = 5'd3;
        tick();
        m_valid = 1'b0;
        stall   = 1'b1;
        checks++;
        if ({regwrite, fwd1_hit, fwd2_hit} !== 3'b110 || fwd_data !== 32'hA5) begin
            errors++;
            $display("FAIL stall_c1 got=%b/%h exp=110/000000a5",
                     {regwrite, fwd1_hit, fwd2_hit}, fwd_data);
        end
        for (int c = 2; c <= 4; c++) begin
            tick();
            checks++;
            if ({regwrite, fwd1_hit, A3} !== {1'b0, 1'b1, 5'd7}) begin
                errors++;
                $display("FAIL stall_c%0d got=%b/%b/%0d exp=0/1/7",
                         c, regwrite, fwd1_hit, A3);
            end
        end
        exp_ret = exp_ret + 1;
        checks++;
        if (retired !== exp_ret) begin
            errors++; $display("FAIL stall_ret got=%0d exp=%0d", retired, exp_ret);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (retired !== exp_ret || fwd1_hit !== 1'b0) begin
            errors++;
            $display("FAIL stall_rel got=%0d/%b exp=%0d/0", retired, fwd1_hit, exp_ret);
        end
    endtask

    task automatic test_flush;
        set_instr(32'h600, 5'd9, 1'b1, 2'b00, 32'h99, 32'h0, 3'b000, 2'b00);
        q_a1 = 5'd9;
        tick();
        m_valid = 1'b0;
        stall   = 1'b1;
        tick();
        exp_ret = exp_ret + 1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        checks++;
        if ({regwrite, fwd1_hit} !== 2'b00) begin
            errors++; $display("FAIL flush_ctl got=%b exp=00", {regwrite, fwd1_hit});
        end
        checks++;
        if (retired !== exp_ret) begin
            errors++; $display("FAIL flush_ret got=%0d exp=%0d", retired, exp_ret);
        end
        tick();
        checks++;
        if (retired !== exp_ret) begin
            errors++; $display("FAIL flush_ret2 got=%0d exp=%0d", retired, exp_ret);
        end
    endtask

    task automatic test_pc8;
        set_instr(32'hFFFF_FFFC, 5'd1, 1'b1, 2'b10, 32'h1, 32'h2, 3'b000, 2'b00);
        tick();
        checks++;
        if (writedata !== 32'h0000_0004) begin
            errors++; $display("FAIL pc8_wrap got=%h exp=00000004", writedata);
        end
        set_instr(32'h0000_0010, 5'd1, 1'b1, 2'b11, 32'h1, 32'h2, 3'b000, 2'b00);
        tick();
        checks++;
        if (writedata !== 32'h0 || regwrite !== 1'b1) begin
            errors++;
            $display("FAIL wbsel11 got=%h/%b exp=00000000/1", writedata, regwrite);
        end
        m_valid = 1'b0;
        tick();
        exp_ret = exp_ret + 2;
    endtask

    task automatic test_rd0;
        set_instr(32'h700, 5'd0, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'h0, 3'b000, 2'b00);
        q_a1 = 5'd0;
        q_a2 = 5'd0;
        tick();
        m_valid = 1'b0;
        checks++;
        if ({regwrite, fwd1_hit, fwd2_hit} !== 3'b000) begin
            errors++;
            $display("FAIL rd0_ctl got=%b exp=000", {regwrite, fwd1_hit, fwd2_hit});
        end
        checks++;
        if (writedata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rd0_wd got=%h exp=deadbeef", writedata);
        end
        tick();
        exp_ret = exp_ret + 1;
        checks++;
        if (retired !== exp_ret) begin
            errors++; $display("FAIL rd0_ret got=%0d exp=%0d", retired, exp_ret);
        end
    endtask

    task automatic test_norw;
        set_instr(32'h800, 5'd5, 1'b0, 2'b00, 32'h42, 32'h0, 3'b000, 2'b00);
        q_a1 = 5'd5;
        tick();
        m_valid = 1'b0;
        checks++;
        if ({regwrite, fwd1_hit} !== 2'b00 || A3 !== 5'd5) begin
            errors++;
            $display("FAIL norw_ctl got=%b/%0d exp=00/5", {regwrite, fwd1_hit}, A3);
        end
        tick();
        exp_ret = exp_ret + 1;
        checks++;
        if (retired !== exp_ret) begin
            errors++; $display("FAIL norw_ret got=%0d exp=%0d", retired, exp_ret);
        end
    endtask

    task automatic test_reset_midstall;
        set_instr(32'h900, 5'd3, 1'b1, 2'b00, 32'h77, 32'h0, 3'b000, 2'b00);
        q_a1 = 5'd3;
        tick();
        m_valid = 1'b0;
        stall   = 1'b1;
        tick();
        reset = 1'b1;
        flush = 1'b1;
        tick();
        checks++;
        if ({regwrite, fwd1_hit, A3} !== {1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL rstmid_ctl got=%b/%b/%0d exp=0/0/0", regwrite, fwd1_hit, A3);
        end
        checks++;
        if (pc !== 32'h0 || writedata !== 32'h0 || retired !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_val got=%h/%h/%0d exp=0/0/0", pc, writedata, retired);
        end
        reset = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        tick();
        checks++;
        if (retired !== 32'h0 || regwrite !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_post got=%0d/%b exp=0/0", retired, regwrite);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_ret    = 32'd0;
        reset      = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        m_valid    = 1'b0;
        m_pc       = 32'h0;
        m_rd       = 5'd0;
        m_regwrite = 1'b0;
        m_wbsel    = 2'b00;
        m_alu      = 32'h0;
        m_memdata  = 32'h0;
        m_ldtype   = 3'b000;
        m_addrlo   = 2'b00;
        q_a1       = 5'd0;
        q_a2       = 5'd0;
        test_reset();
        test_alu();
        test_load();
        test_stall();
        test_flush();
        test_pc8();
        test_rd0();
        test_norw();
        test_reset_midstall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have inputs m_valid (1), m_pc (32), m_rd (5), m_regwrite (1), m_wbsel (2), m_alu (32), m_memdata (32), m_ldtype (3) and m_addrlo (2): the instruction leaving MEM.
REQ-004 SHALL have inputs stall (1) and flush (1): pipeline control.
REQ-005 SHALL have outputs pc (32), A3 (5), writedata (32) and regwrite (1): the GRF write port.
REQ-006 SHALL have inputs q_a1 (5) and q_a2 (5), and outputs fwd1_hit (1), fwd2_hit (1) and fwd_data (32): the decode-stage bypass query.
REQ-007 SHALL have output retired (32): the count of instructions retired.

Function
REQ-008 SHALL hold one stage register (valid, pc, rd, regwrite, wbsel, alu, memdata, ldtype, addrlo) plus a done bit.
REQ-009 SHALL apply this priority on each rising edge: reset > flush > stall > capture.
REQ-010 On flush, SHALL clear valid to 0 and leave the other fields don't-care.
REQ-011 On stall without flush, SHALL hold the stage register unchanged and set done to 1 if valid is 1.
REQ-012 On capture, SHALL load all m_* inputs into the stage register and clear done to 0.
REQ-013 SHALL drive regwrite as valid & regwrite_r & (rd != 0) & !done, so each held instruction writes exactly once.
REQ-014 SHALL drive A3 = rd and pc = stage pc combinationally.
REQ-015 SHALL select writedata by wbsel: 00 = alu, 01 = extended load data, 10 = pc + 8 (mod 2^32), 11 = 32'h0000_0000.
REQ-016 SHALL use little-endian load byte lanes: byte k = memdata[8k+7:8k], selected by addrlo; the halfword is selected by addrlo[1] (0 = [15:0], 1 = [31:16]).
REQ-017 SHALL decode ldtype as 000 = lw, 001 = lb (sign-extend), 010 = lbu, 011 = lh (sign-extend), 100 = lhu; values 101-111 SHALL behave as lw.
REQ-018 SHALL assert fwdN_hit when valid & regwrite_r & rd != 0 & q_aN == rd; the done bit SHALL NOT mask the hit; fwd_data SHALL equal writedata.
REQ-019 SHALL increment retired by 1 in each cycle where regwrite_r-independent valid & !done holds, wrapping from 32'hFFFF_FFFF to 0.
REQ-020 SHALL treat a rd = 0 write as retiring without asserting regwrite or a forward hit.

Reset
REQ-021 On reset, SHALL clear valid, done and retired to 0 and every stage field to 0.
REQ-022 After reset, SHALL give outputs pc = 0, A3 = 0, writedata = 0, regwrite = 0, fwd hits = 0 and retired = 0.
REQ-023 Reset SHALL override simultaneous flush and stall, and an instruction held mid-stall SHALL be discarded.

Configuration
REQ-024 The macro WB_LOADEXT_EN, when defined, SHALL enable the byte/half extraction and extension of REQ-016 and REQ-017.
REQ-025 When WB_LOADEXT_EN is undefined, wbsel = 01 SHALL pass m_memdata unchanged regardless of ldtype and addrlo, and no extension logic SHALL be built.

Verification
REQ-026 Capture valid=1, rd=5, wbsel=00, alu=32'h1234_5678, pc=32'h0000_3000 -> next cycle regwrite=1, A3=5, writedata=32'h1234_5678, pc=32'h0000_3000; retired=1 on the following cycle.
REQ-027 With the macro on, memdata=32'h8070_60F0, ldtype=001, addrlo=0 -> writedata=32'hFFFF_FFF0; ldtype=100, addrlo=2 -> 32'h0000_8070.
REQ-028 Capture rd=7 then hold stall for 3 cycles -> regwrite is high in the first cycle only, fwd1_hit=1 with q_a1=7 in all 4 cycles, and retired increments once.
REQ-029 Assert flush and stall together while an instruction is valid -> next cycle valid=0, regwrite=0 and retired unchanged.
REQ-030 Capture wbsel=10 with pc=32'hFFFF_FFFC -> writedata=32'h0000_0004.
REQ-031 Capture rd=0, alu=32'hDEAD_BEEF, regwrite=1 -> regwrite=0 and fwd hits=0 with q_a1=0, and retired increments.
